multi_channel_csr: RTL and testbench
====================================

Name: multi_channel_csr

Overview:
Parametrised successor of the single-channel Avalon-MM control register. It serves CH_NUM independent pattern-matcher channels. Each channel has its own enable, its own shadowed key-pattern words and a match counter. Shared logic adds an atomic commit of the shadowed patterns to the active outputs, a write-1-to-clear interrupt status with a mask, and a single interrupt line. It sits between the host Avalon-MM master and the matcher datapath.

Parameters:
REG_WIDTH, 32, data width of every register and pattern word.
CH_NUM, 4, number of matcher channels (1..16).
PAT_WORDS, 3, key-pattern words per channel (1..6).
ADDR_WIDTH, 8, number of low address bits decoded. Must be at least clog2((CH_NUM+1)*CH_STRIDE).

Ports:
clk_i  input  1  single clock; all logic on the rising edge.
srst_i  input  1  synchronous, active-high reset.
amm_slave_if  avalon_mm_if.slave  -  uses address, write, writedata, read, waitrequest, readdata, readdatavalid.
match_i  input  CH_NUM  per-channel one-cycle match pulse from the datapath.
busy_i  input  1  datapath busy; a commit is held off while this is high.
pattern_o  output  CH_NUM x PAT_WORDS x REG_WIDTH  active (committed) pattern words.
ch_en_o  output  CH_NUM  channel enable = global_en AND channel enable bit.
commit_done_o  output  1  one-cycle pulse when the active patterns update.
irq_o  output  1  registered OR of (irq_status AND irq_mask).

Behaviour:
- Address map, word addressed:
  - CH_STRIDE = next power of two of PAT_WORDS+2.
  - 0x0 CTRL: bit0 global_en (RW), bit1 commit (write 1 only, reads 0).
  - 0x1 STATUS (RO): bit0 commit_pending.
  - 0x2 IRQ_STATUS: W1C, bit c = channel c matched.
  - 0x3 IRQ_MASK: RW, low CH_NUM bits.
  - Channel c base = (c+1)*CH_STRIDE:
    - +0 CH_CTRL: bit0 enable (RW).
    - +1 MATCH_CNT: RO; any write clears it.
    - +2..+2+PAT_WORDS-1: pattern shadow words (RW).
- Unmapped addresses and unimplemented bits:
  - Reads return 0.
  - Writes are ignored.
  - Writes to RO registers are ignored.
- Handshake:
  - waitrequest is constant 0.
  - Read latency is exactly 1: readdatavalid is high in the cycle after read is sampled, with readdata valid in that same cycle.
  - readdatavalid is 0 when there is no read.
  - readdata holds its last value between reads.
- Simultaneous read and write to the same address: the read returns the pre-write value and the write takes effect.
- Enable bits (global and per-channel) take effect immediately, 1 cycle after the write, with no commit needed.
- Commit:
  - Writing 1 to CTRL bit1 sets commit_pending on the next edge.
  - On the first edge where commit_pending=1 and busy_i=0, all shadow words are copied into the active words, commit_pending clears and commit_done_o pulses.
  - pattern_o and commit_done_o therefore change together, at the earliest 2 cycles after the write.
  - A second commit write while a commit is pending has no additional effect.
  - A shadow write in the same cycle as the copy: the copy takes the old shadow value; the new value stays in the shadow.
- Match counters:
  - Each match_i[c] pulse increments MATCH_CNT[c]; the counter saturates at all-ones.
  - A pulse also sets IRQ_STATUS[c]; this happens regardless of channel enable.
  - Clear-write and pulse in the same cycle: counter = 1.
  - W1C write and set event on the same bit in the same cycle: set wins.
- irq_o is registered, so it follows a status or mask change by 1 cycle.
- Reset values:
  - Shadow and active patterns all-ones.
  - All enables 0.
  - commit_pending 0.
  - Counters 0.
  - IRQ_STATUS and IRQ_MASK 0.
  - readdata 0, readdatavalid 0.
  - commit_done_o 0, irq_o 0.
- Reset mid-operation: an asserted srst_i aborts a pending commit; active patterns return to all-ones.

Decomposition:
- Package multi_channel_csr_pkg holds:
  - Address offsets: CTRL, STATUS, IRQ_STATUS, IRQ_MASK, CH_CTRL, MATCH_CNT, PAT_BASE.
  - Bit positions: GLOBAL_EN, COMMIT, PENDING, CH_EN.
  - A ch_stride(PAT_WORDS) function.
- Sub-module csr_channel, generated CH_NUM times. It holds:
  - Enable, shadow words, active words and the saturating counter.
  - Inputs: write strobe, word offset, data, commit strobe, counter clear, match pulse.
  - Outputs: read mux word, match-set pulse.
- The top level holds address decode, global registers, commit sequencing, the read pipeline and the IRQ logic.

Test Plan:
- Reset then read 0x0, 0x1, 0x2, 0x3 and 0x0A (ch0 word0) -> readdata 0, 0, 0, 0, 0xFFFFFFFF; readdatavalid exactly 1 cycle after each read; pattern_o all 0xFFFFFFFF.
- Write 0x12=0xDEADBEEF (ch1 word0), busy_i=0 -> pattern_o[1][0] unchanged. Then write 0x0=0x3 -> commit_done_o pulses and pattern_o[1][0]=0xDEADBEEF 2 cycles later; ch_en_o=0.
- Hold busy_i=1, write commit, wait 10 cycles -> STATUS=1, pattern_o unchanged. Drop busy_i -> update and commit_done_o on the next edge; STATUS then reads 0.
- Write IRQ_MASK=0x4, pulse match_i[2] 3 times -> MATCH_CNT ch2 (0x19)=3, IRQ_STATUS=0x4, irq_o=1. Write 0x2=0x4 in the same cycle as a match_i[2] pulse -> IRQ_STATUS stays 0x4.
- Write 0x09=0 in the same cycle as a match_i[0] pulse -> 0x09 reads 1. Force the counter near saturation with 0xFFFFFFFF pulses -> it holds 0xFFFFFFFF.
- Simultaneous read+write 0x0A=0x12345678 -> readdata = old value 0xFFFFFFFF; the next read returns 0x12345678. A write to 0x07 (unmapped) followed by a read -> 0.

Source files
------------

// File: rtl/multi_channel_csr_pkg.sv
// Shared register map, bit positions and stride helper for multi_channel_csr.
package multi_channel_csr_pkg;

    // Global register word offsets (channel region index 0)
    localparam int CTRL       = 0;
    localparam int STATUS     = 1;
    localparam int IRQ_STATUS = 2;
    localparam int IRQ_MASK   = 3;

    // Per-channel word offsets inside one channel stride
    localparam int CH_CTRL    = 0;
    localparam int MATCH_CNT  = 1;
    localparam int PAT_BASE   = 2;

    // Bit positions
    localparam int GLOBAL_EN  = 0;
    localparam int COMMIT     = 1;
    localparam int PENDING    = 0;
    localparam int CH_EN      = 0;

    // Next power of two of PAT_WORDS+2 (PAT_WORDS is at most 6, so 8 is the ceiling)
    function automatic int ch_stride(input int pat_words);
        int s;
        s = 1;
        for (int i = 0; i < 4; i++) begin
            if (s < pat_words + 2) s = s * 2;
        end
        return s;
    endfunction

endpackage

// File: rtl/multi_channel_csr_channel.sv
// One matcher channel: enable bit, shadow/active pattern words and a saturating match counter.
module csr_channel
    import multi_channel_csr_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int PAT_WORDS  = 3,
    parameter int OFF_WIDTH  = 3
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           wr,
    input  logic [OFF_WIDTH-1:0]           off,
    input  logic [REG_WIDTH-1:0]           wdata,
    input  logic                           commit,
    input  logic                           cnt_clr,
    input  logic                           match,
    output logic [REG_WIDTH-1:0]           rdata,
    output logic                           match_set,
    output logic                           en,
    output logic [PAT_WORDS*REG_WIDTH-1:0] pattern
);

    logic                 en_reg;
    logic [REG_WIDTH-1:0] cnt_reg;
    logic [REG_WIDTH-1:0] shadow_reg [PAT_WORDS];
    logic [REG_WIDTH-1:0] active_reg [PAT_WORDS];

    always_ff @(posedge clk) begin
        if (srst) begin
            en_reg  <= 1'b0;
            cnt_reg <= '0;
        end else begin
            if (wr && off == OFF_WIDTH'(CH_CTRL)) en_reg <= wdata[CH_EN];
            // A clear coinciding with a pulse leaves the pulse counted
            if (cnt_clr)
                cnt_reg <= match ? REG_WIDTH'(1) : '0;
            else if (match && cnt_reg != '1)
                cnt_reg <= cnt_reg + REG_WIDTH'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < PAT_WORDS; gi++) begin : gen_word
            // Copy uses the pre-edge shadow, so a same-cycle shadow write lands only in the shadow
            always_ff @(posedge clk) begin
                if (srst) begin
                    shadow_reg[gi] <= '1;
                    active_reg[gi] <= '1;
                end else begin
                    if (commit) active_reg[gi] <= shadow_reg[gi];
                    if (wr && off == OFF_WIDTH'(PAT_BASE + gi)) shadow_reg[gi] <= wdata;
                end
            end
            assign pattern[gi*REG_WIDTH +: REG_WIDTH] = active_reg[gi];
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (off == OFF_WIDTH'(CH_CTRL)) rdata[CH_EN] = en_reg;
        if (off == OFF_WIDTH'(MATCH_CNT)) rdata = cnt_reg;
        for (int w = 0; w < PAT_WORDS; w++) begin
            if (off == OFF_WIDTH'(PAT_BASE + w)) rdata = shadow_reg[w];
        end
    end

    assign match_set = match;
    assign en        = en_reg;

endmodule

// File: rtl/multi_channel_csr.sv
// Avalon-MM CSR block for CH_NUM pattern-matcher channels with atomic pattern commit and masked IRQ.
module multi_channel_csr
    import multi_channel_csr_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int CH_NUM     = 4,
    parameter int PAT_WORDS  = 3,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                  clk_i,
    input  logic                                  srst_i,
    input  logic [ADDR_WIDTH-1:0]                 amm_address,
    input  logic                                  amm_write,
    input  logic [REG_WIDTH-1:0]                  amm_writedata,
    input  logic                                  amm_read,
    output logic                                  amm_waitrequest,
    output logic [REG_WIDTH-1:0]                  amm_readdata,
    output logic                                  amm_readdatavalid,
    input  logic [CH_NUM-1:0]                     match_i,
    input  logic                                  busy_i,
    output logic [CH_NUM*PAT_WORDS*REG_WIDTH-1:0] pattern_o,
    output logic [CH_NUM-1:0]                     ch_en_o,
    output logic                                  commit_done_o,
    output logic                                  irq_o
);

    localparam int CH_STRIDE = ch_stride(PAT_WORDS);
    localparam int SW        = $clog2(CH_STRIDE);
    localparam int HW        = ADDR_WIDTH - SW;

    logic [HW-1:0]        region;
    logic [SW-1:0]        off;
    logic                 glob_sel;
    logic [CH_NUM-1:0]    ch_sel;
    logic [CH_NUM-1:0]    ch_en;
    logic [CH_NUM-1:0]    match_set;
    logic [REG_WIDTH-1:0] ch_rdata [CH_NUM];
    logic [REG_WIDTH-1:0] rd_mux;

    logic                 global_en_reg;
    logic                 pending_reg;
    logic                 commit_done_reg;
    logic [CH_NUM-1:0]    irq_status_reg;
    logic [CH_NUM-1:0]    irq_mask_reg;
    logic                 irq_reg;
    logic [REG_WIDTH-1:0] readdata_reg;
    logic                 readdatavalid_reg;
    logic                 commit_fire;

    assign region      = amm_address[ADDR_WIDTH-1:SW];
    assign off         = amm_address[SW-1:0];
    assign glob_sel    = (region == '0);
    assign commit_fire = pending_reg && !busy_i;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : gen_ch
            assign ch_sel[gi] = (region == HW'(gi + 1));

            csr_channel #(
                .REG_WIDTH (REG_WIDTH),
                .PAT_WORDS (PAT_WORDS),
                .OFF_WIDTH (SW)
            ) u_ch (
                .clk       (clk_i),
                .srst      (srst_i),
                .wr        (amm_write && ch_sel[gi]),
                .off       (off),
                .wdata     (amm_writedata),
                .commit    (commit_fire),
                .cnt_clr   (amm_write && ch_sel[gi] && off == SW'(MATCH_CNT)),
                .match     (match_i[gi]),
                .rdata     (ch_rdata[gi]),
                .match_set (match_set[gi]),
                .en        (ch_en[gi]),
                .pattern   (pattern_o[gi*PAT_WORDS*REG_WIDTH +: PAT_WORDS*REG_WIDTH])
            );

            assign ch_en_o[gi] = global_en_reg & ch_en[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            global_en_reg   <= 1'b0;
            pending_reg     <= 1'b0;
            commit_done_reg <= 1'b0;
            irq_status_reg  <= '0;
            irq_mask_reg    <= '0;
            irq_reg         <= 1'b0;
        end else begin
            commit_done_reg <= commit_fire;
            irq_reg         <= |(irq_status_reg & irq_mask_reg);
            if (amm_write && glob_sel && off == SW'(CTRL) && amm_writedata[COMMIT])
                pending_reg <= 1'b1;
            else if (commit_fire)
                pending_reg <= 1'b0;
            if (amm_write && glob_sel && off == SW'(CTRL))
                global_en_reg <= amm_writedata[GLOBAL_EN];
            if (amm_write && glob_sel && off == SW'(IRQ_MASK))
                irq_mask_reg <= amm_writedata[CH_NUM-1:0];
            // New match events win over a same-cycle W1C on the same bit
            if (amm_write && glob_sel && off == SW'(IRQ_STATUS))
                irq_status_reg <= (irq_status_reg & ~amm_writedata[CH_NUM-1:0]) | match_set;
            else
                irq_status_reg <= irq_status_reg | match_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (glob_sel) begin
            if (off == SW'(CTRL))       rd_mux[GLOBAL_EN] = global_en_reg;
            if (off == SW'(STATUS))     rd_mux[PENDING]   = pending_reg;
            if (off == SW'(IRQ_STATUS)) rd_mux = REG_WIDTH'(irq_status_reg);
            if (off == SW'(IRQ_MASK))   rd_mux = REG_WIDTH'(irq_mask_reg);
        end
        for (int c = 0; c < CH_NUM; c++) begin
            if (ch_sel[c]) rd_mux = ch_rdata[c];
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
        end else begin
            readdatavalid_reg <= amm_read;
            if (amm_read) readdata_reg <= rd_mux;
        end
    end

    assign amm_waitrequest   = 1'b0;
    assign amm_readdata      = readdata_reg;
    assign amm_readdatavalid = readdatavalid_reg;
    assign commit_done_o     = commit_done_reg;
    assign irq_o             = irq_reg;

endmodule

// File: tb/tb_multi_channel_csr.sv
// Directed self-checking bench for multi_channel_csr (default build plus a narrow build for saturation).
module tb_multi_channel_csr;

    logic         clk;
    logic         srst;
    logic [7:0]   address;
    logic         write;
    logic [31:0]  writedata;
    logic         read;
    logic         waitrequest;
    logic [31:0]  readdata;
    logic         readdatavalid;
    logic [3:0]   match;
    logic         busy;
    logic [383:0] pattern;
    logic [3:0]   ch_en;
    logic         commit_done;
    logic         irq;

    logic [3:0]   s_address;
    logic         s_write;
    logic [7:0]   s_writedata;
    logic         s_read;
    logic         s_waitrequest;
    logic [7:0]   s_readdata;
    logic         s_readdatavalid;
    logic [0:0]   s_match;
    logic [7:0]   s_pattern;
    logic [0:0]   s_ch_en;
    logic         s_commit_done;
    logic         s_irq;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    logic [31:0] rd;

    multi_channel_csr dut (
        .clk_i             (clk),
        .srst_i            (srst),
        .amm_address       (address),
        .amm_write         (write),
        .amm_writedata     (writedata),
        .amm_read          (read),
        .amm_waitrequest   (waitrequest),
        .amm_readdata      (readdata),
        .amm_readdatavalid (readdatavalid),
        .match_i           (match),
        .busy_i            (busy),
        .pattern_o         (pattern),
        .ch_en_o           (ch_en),
        .commit_done_o     (commit_done),
        .irq_o             (irq)
    );

    multi_channel_csr #(
        .REG_WIDTH  (8),
        .CH_NUM     (1),
        .PAT_WORDS  (1),
        .ADDR_WIDTH (4)
    ) dut_small (
        .clk_i             (clk),
        .srst_i            (srst),
        .amm_address       (s_address),
        .amm_write         (s_write),
        .amm_writedata     (s_writedata),
        .amm_read          (s_read),
        .amm_waitrequest   (s_waitrequest),
        .amm_readdata      (s_readdata),
        .amm_readdatavalid (s_readdatavalid),
        .match_i           (s_match),
        .busy_i            (1'b0),
        .pattern_o         (s_pattern),
        .ch_en_o           (s_ch_en),
        .commit_done_o     (s_commit_done),
        .irq_o             (s_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        check($sformatf("rdvalid@%02h", a), {31'b0, readdatavalid}, 32'h1);
        d = readdata;
    endtask

    task automatic read_check(input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check($sformatf("rd@%02h", a), v, exp);
    endtask

    task automatic pulse(input logic [3:0] m);
        match = m;
        tick();
        match = 4'h0;
    endtask

    initial begin
        srst = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        match = '0; busy = 1'b0;
        s_address = '0; s_write = 1'b0; s_writedata = '0; s_read = 1'b0; s_match = '0;
        repeat (3) tick();
        srst = 1'b0;
        tick();

        // Reset state
        check("rst_rdvalid", {31'b0, readdatavalid}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_commit_done", {31'b0, commit_done}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_ch_en", {28'b0, ch_en}, 32'h0);
        check("rst_pattern_ones", {31'b0, &pattern}, 32'h1);
        check("rst_waitrequest", {31'b0, waitrequest}, 32'h0);
        read_check(8'h00, 32'h0);
        read_check(8'h01, 32'h0);
        read_check(8'h02, 32'h0);
        read_check(8'h03, 32'h0);
        read_check(8'h0A, 32'hFFFF_FFFF);
        tick();
        check("rdvalid_idle", {31'b0, readdatavalid}, 32'h0);
        check("readdata_hold", readdata, 32'hFFFF_FFFF);

        // Shadow write alone does not touch active; commit updates 2 cycles after the CTRL write
        bus_write(8'h12, 32'hDEAD_BEEF);
        check("pat10_before_commit", pattern[96 +: 32], 32'hFFFF_FFFF);
        bus_write(8'h00, 32'h3);
        check("commit_done_early", {31'b0, commit_done}, 32'h0);
        check("pat10_early", pattern[96 +: 32], 32'hFFFF_FFFF);
        tick();
        check("commit_done_pulse", {31'b0, commit_done}, 32'h1);
        check("pat10_committed", pattern[96 +: 32], 32'hDEAD_BEEF);
        check("ch_en_no_ch_bits", {28'b0, ch_en}, 32'h0);
        tick();
        check("commit_done_one_cycle", {31'b0, commit_done}, 32'h0);
        bus_write(8'h10, 32'h1);
        check("ch_en_ch1", {28'b0, ch_en}, 32'h2);
        read_check(8'h00, 32'h1);

        // Commit held off by busy
        busy = 1'b1;
        bus_write(8'h12, 32'hCAFE_F00D);
        bus_write(8'h00, 32'h3);
        repeat (10) tick();
        read_check(8'h01, 32'h1);
        check("pat10_busy_hold", pattern[96 +: 32], 32'hDEAD_BEEF);
        check("commit_done_busy", {31'b0, commit_done}, 32'h0);
        busy = 1'b0;
        tick();
        check("commit_done_after_busy", {31'b0, commit_done}, 32'h1);
        check("pat10_after_busy", pattern[96 +: 32], 32'hCAFE_F00D);
        read_check(8'h01, 32'h0);

        // Match counter, IRQ status and mask
        bus_write(8'h03, 32'h4);
        pulse(4'h4);
        pulse(4'h4);
        pulse(4'h4);
        read_check(8'h19, 32'h3);
        read_check(8'h02, 32'h4);
        check("irq_high", {31'b0, irq}, 32'h1);
        match = 4'h4;
        bus_write(8'h02, 32'h4);
        match = 4'h0;
        read_check(8'h02, 32'h4);
        bus_write(8'h02, 32'h4);
        read_check(8'h02, 32'h0);
        check("irq_low", {31'b0, irq}, 32'h0);
        read_check(8'h19, 32'h4);

        // Counter clear collides with a pulse
        pulse(4'h1);
        pulse(4'h1);
        match = 4'h1;
        bus_write(8'h09, 32'h0);
        match = 4'h0;
        read_check(8'h09, 32'h1);
        bus_write(8'h09, 32'h5);
        read_check(8'h09, 32'h0);

        // Simultaneous read and write returns the old value
        address = 8'h0A; writedata = 32'h1234_5678; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        check("rw_rdvalid", {31'b0, readdatavalid}, 32'h1);
        check("rw_old_value", readdata, 32'hFFFF_FFFF);
        read_check(8'h0A, 32'h1234_5678);

        // Unmapped locations
        bus_write(8'h07, 32'hFFFF_FFFF);
        read_check(8'h07, 32'h0);
        read_check(8'h28, 32'h0);
        read_check(8'h0D, 32'h0);

        // Reset aborts a pending commit and restores active patterns
        busy = 1'b1;
        bus_write(8'h00, 32'h2);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        busy = 1'b0;
        tick();
        check("srst_pattern_ones", {31'b0, &pattern}, 32'h1);
        check("srst_commit_done", {31'b0, commit_done}, 32'h0);
        read_check(8'h01, 32'h0);

        // Saturation on the 8-bit build: counter at 0x05
        s_match = 1'b1;
        repeat (254) tick();
        s_match = 1'b0;
        s_address = 4'h5; s_read = 1'b1;
        tick();
        s_read = 1'b0;
        check("sat_fe", {24'b0, s_readdata}, 32'hFE);
        s_match = 1'b1;
        repeat (3) tick();
        s_match = 1'b0;
        s_read = 1'b1;
        tick();
        s_read = 1'b0;
        check("sat_hold_ff", {24'b0, s_readdata}, 32'hFF);
        check("sat_rdvalid", {31'b0, s_readdatavalid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
